sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider_if.sv | 24 ++
 rtl/sequential_divider.sv | 116 +++++++++++
 tb/tb_sequential_divider.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// master drives requests and operands; slave returns results and status.
interface sequential_divider_if #(
    parameter int OPERAND_SIZE = 4
);
    logic                    start;
    logic [OPERAND_SIZE-1:0] dividend;
    logic [OPERAND_SIZE-1:0] divisor;
    logic [OPERAND_SIZE-1:0] quotient;
    logic [OPERAND_SIZE-1:0] remainder;
    logic                    busy;
    logic                    done;
    logic                    div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to DONE with quotient all ones.
module sequential_divider #(
    parameter int OPERAND_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  areset,
    sequential_divider_if.slave   dif
);
    localparam int N     = OPERAND_SIZE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       rem_reg, rem_next;
    logic [N-1:0]       dvd_reg, dvd_next;
    logic [N-1:0]       dsr_reg, dsr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N-1:0]       quo_out_reg, quo_out_next;
    logic [N-1:0]       rem_out_reg, rem_out_next;
    logic               dbz_reg, dbz_next;

    // Trial subtraction is done N+1 bits wide so the shifted partial
    // remainder can never overflow before the divisor is subtracted.
    logic [N:0]         shifted;
    logic [N:0]         diff;
    logic               qbit;
    logic [N-1:0]       rem_iter;
    logic [N-1:0]       dvd_iter;

    assign shifted  = {rem_reg, dvd_reg[N-1]};
    assign diff     = shifted - {1'b0, dsr_reg};
    assign qbit     = ~diff[N];
    assign rem_iter = qbit ? diff[N-1:0] : shifted[N-1:0];
    // Dividend bits shift out the top while quotient bits fill in at the bottom.
    assign dvd_iter = (dvd_reg << 1) | N'(qbit);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            cnt_reg     <= '0;
            quo_out_reg <= '0;
            rem_out_reg <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rem_reg     <= rem_next;
            dvd_reg     <= dvd_next;
            dsr_reg     <= dsr_next;
            cnt_reg     <= cnt_next;
            quo_out_reg <= quo_out_next;
            rem_out_reg <= rem_out_next;
            dbz_reg     <= dbz_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        dvd_next     = dvd_reg;
        dsr_next     = dsr_reg;
        cnt_next     = cnt_reg;
        quo_out_next = quo_out_reg;
        rem_out_next = rem_out_reg;
        dbz_next     = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new request exactly like IDLE for full throughput.
                if (dif.start) begin
                    if (dif.divisor == '0) begin
                        state_next   = DONE;
                        quo_out_next = '1;
                        rem_out_next = dif.dividend;
                        dbz_next     = 1'b1;
                    end else begin
                        state_next = CALC;
                        rem_next   = '0;
                        dvd_next   = dif.dividend;
                        dsr_next   = dif.divisor;
                        cnt_next   = CNT_W'(N);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                rem_next = rem_iter;
                dvd_next = dvd_iter;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next   = DONE;
                    quo_out_next = dvd_iter;
                    rem_out_next = rem_iter;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dif.busy        = (state_reg == CALC);
    assign dif.done        = (state_reg == DONE);
    assign dif.div_by_zero = dbz_reg;
    assign dif.quotient    = quo_out_reg;
    assign dif.remainder   = rem_out_reg;
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: expected results are queued when a
// request is driven and popped when the matching done pulse is observed.
module tb_sequential_divider;
    logic clk;
    logic areset;

    sequential_divider_if #(.OPERAND_SIZE(4)) dif ();

    sequential_divider #(.OPERAND_SIZE(4)) dut (
        .clk    (clk),
        .areset (areset),
        .dif    (dif)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   check_count = 0;
    int   pass_count  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired: got no finish, want finish before 300000ns");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] dd, input logic [3:0] ds);
        exp_t e;
        if (ds == 4'd0) begin
            e.q = 4'hF; e.r = dd; e.dz = 1'b1;
        end else begin
            e.q = dd / ds; e.r = dd % ds; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Pulse start for one cycle and queue the expected result; operands are
    // scrambled right after acceptance so a design that resamples them is caught.
    task automatic drive_op(input logic [3:0] dd, input logic [3:0] ds);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = dd;
        dif.divisor  = ds;
        sb.push_back(model(dd, ds));
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = 4'($urandom);
        dif.divisor  = 4'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dif.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        areset       = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = 4'd0;
        dif.divisor  = 4'd0;
        #12;
        check_count++;
        if ({dif.busy, dif.done, dif.div_by_zero} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {dif.busy, dif.done, dif.div_by_zero});
        else pass_count++;
        check_count++;
        if ({dif.quotient, dif.remainder} !== 8'h00)
            $display("FAIL reset_results got %h want 00", {dif.quotient, dif.remainder});
        else pass_count++;
        @(negedge clk);
        areset = 1'b1;
    endtask

    task automatic test_basic;
        exp_t e;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd7; dif.divisor = 4'd2;
        sb.push_back(model(4'd7, 4'd2));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                dif.start = 1'b0; dif.dividend = 4'd15; dif.divisor = 4'd1;
            end
            check_count++;
            if (dif.busy !== (c <= 4))
                $display("FAIL basic_busy cycle %0d got %b want %b", c, dif.busy, (c <= 4));
            else pass_count++;
            check_count++;
            if (dif.done !== (c == 5))
                $display("FAIL basic_done cycle %0d got %b want %b", c, dif.done, (c == 5));
            else pass_count++;
        end
        e = sb.pop_front();
        check_count++;
        if ({dif.quotient, dif.remainder, dif.div_by_zero} !== {e.q, e.r, e.dz})
            $display("FAIL basic_result 7/2 got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r, e.dz);
        else pass_count++;
    endtask

    task automatic test_corners;
        logic [3:0] dds[3] = '{4'd15, 4'd15, 4'd3};
        logic [3:0] dss[3] = '{4'd15, 4'd1,  4'd5};
        exp_t e;
        bit   ok;
        for (int i = 0; i < 3; i++) begin
            drive_op(dds[i], dss[i]);
            wait_done(ok);
            e = sb.pop_front();
            check_count++;
            if (!ok) $display("FAIL corner_timeout %0d/%0d got no done want done", dds[i], dss[i]);
            else pass_count++;
            check_count++;
            if ({dif.quotient, dif.remainder, dif.div_by_zero} !== {e.q, e.r, e.dz})
                $display("FAIL corner_result %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                         dds[i], dss[i], dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r, e.dz);
            else pass_count++;
        end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero;
        exp_t e;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd9; dif.divisor = 4'd0;
        sb.push_back(model(4'd9, 4'd0));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                dif.start = 1'b0;
                e = sb.pop_front();
                check_count++;
                if ({dif.quotient, dif.remainder} !== {e.q, e.r})
                    $display("FAIL dbz_result got q=%0d r=%0d want q=%0d r=%0d",
                             dif.quotient, dif.remainder, e.q, e.r);
                else pass_count++;
            end
            check_count++;
            if ({dif.busy, dif.done, dif.div_by_zero} !== {1'b0, (c == 1), (c == 1)})
                $display("FAIL dbz_flags cycle %0d got busy/done/dz=%b want %b", c,
                         {dif.busy, dif.done, dif.div_by_zero}, {1'b0, (c == 1), (c == 1)});
            else pass_count++;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd6; dif.divisor = 4'd4;
        sb.push_back(model(4'd6, 4'd4));
        sb.push_back(model(4'd13, 4'd3));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                dif.dividend = 4'd13; dif.divisor = 4'd3;
            end
            if (c == 6) begin
                dif.dividend = 4'd2; dif.divisor = 4'd7;
            end
            if (c == 9) dif.start = 1'b0;
            check_count++;
            if ({dif.busy, dif.done} !== {((c >= 1 && c <= 4) || (c >= 6 && c <= 9)), (c == 5 || c == 10)})
                $display("FAIL b2b_flags cycle %0d got busy/done=%b want %b", c, {dif.busy, dif.done},
                         {((c >= 1 && c <= 4) || (c >= 6 && c <= 9)), (c == 5 || c == 10)});
            else pass_count++;
            if (dif.done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                check_count++;
                if ({dif.quotient, dif.remainder, dif.div_by_zero} !== {e.q, e.r, e.dz})
                    $display("FAIL b2b_result cycle %0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                             c, dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r, e.dz);
                else pass_count++;
            end
        end
        check_count++;
        if (sb.size() != 0) $display("FAIL b2b_count got %0d pending want 0", sb.size());
        else pass_count++;
        sb.delete();
    endtask

    task automatic test_reset_abort;
        exp_t e;
        bit   ok;
        bit   saw_done;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd10; dif.divisor = 4'd3;
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        #1;
        check_count++;
        if ({dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder} !== 11'd0)
            $display("FAIL abort_outputs got %b want 0",
                     {dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder});
        else pass_count++;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) areset = 1'b1;
            if (dif.done === 1'b1) saw_done = 1'b1;
        end
        check_count++;
        if (saw_done) $display("FAIL abort_no_done got done=1 want 0");
        else pass_count++;
        drive_op(4'd10, 4'd3);
        wait_done(ok);
        e = sb.pop_front();
        check_count++;
        if (!ok || {dif.quotient, dif.remainder} !== {e.q, e.r})
            $display("FAIL abort_retry got done=%b q=%0d r=%0d want done=1 q=%0d r=%0d",
                     ok, dif.quotient, dif.remainder, e.q, e.r);
        else pass_count++;
        @(negedge clk);
    endtask

    task automatic test_sweep;
        exp_t e;
        bit   ok;
        for (int dd = 0; dd < 16; dd++) begin
            for (int ds = 0; ds < 16; ds++) begin
                drive_op(4'(dd), 4'(ds));
                wait_done(ok);
                e = sb.pop_front();
                check_count++;
                if (!ok || {dif.quotient, dif.remainder, dif.div_by_zero} !== {e.q, e.r, e.dz})
                    $display("FAIL sweep %0d/%0d got done=%b q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                             dd, ds, ok, dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r, e.dz);
                else pass_count++;
                if (ds != 0) begin
                    check_count++;
                    if ((int'(dif.quotient) * ds + int'(dif.remainder) != dd) || (int'(dif.remainder) >= ds))
                        $display("FAIL sweep_identity %0d/%0d got q=%0d r=%0d want q*d+r=%0d r<%0d",
                                 dd, ds, dif.quotient, dif.remainder, dd, ds);
                    else pass_count++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_by_zero();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
